// File: rtl/fmac_pkg.sv
// Shared types and helpers for the FMAC multiply front end.
// Holds the Booth digit action, the sequencer states and the digit-count helpers.
package fmac_pkg;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_act_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned operands need one extra digit to cover the zero-extended top bits.
  function automatic int booth_digits(input int width, input logic is_signed);
    return is_signed ? width / 2 : width / 2 + 1;
  endfunction

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/booth_radix4_enc.sv
// Radix-4 Booth recoder: one 3-bit multiplier triplet to a {neg, two, one} action.
// Purely combinational, zero latency, no flow control.
module booth_radix4_enc
  import fmac_pkg::*;
(
  input  logic [2:0]  trip,
  output booth_act_t  act
);

  assign act.one = trip[1] ^ trip[0];
  assign act.two = (~trip[2] & trip[1] & trip[0]) | (trip[2] & ~trip[1] & ~trip[0]);
  assign act.neg = trip[2];

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, DPC digits per clock, exact 2*WIDTH-bit product.
// Result valid ceil(D/DPC) edges after accept; holds in DONE (in_ready=0) until out_ready.
module booth_seq_mult
  import fmac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int AW   = 2 * WIDTH + 2;
  localparam int CMAX = ceil_div(booth_digits(WIDTH, 1'b0), DPC);
  localparam int BW   = 2 * CMAX * DPC;
  localparam int CW   = $clog2(CMAX * DPC + 1);

  state_t               state_q, state_d;
  logic                 sgn_q;
  logic [AW-1:0]        mcand_q;
  logic [BW:0]          bx_q;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 last_grp;
  logic                 accept;
  logic [AW-1:0]        pp [DPC];

  assign accept   = in_valid && in_ready;
  assign last_grp = (int'(cnt_q) + DPC) >= booth_digits(WIDTH, sgn_q);

  // mcand_q already carries the 2*cnt shift; only the in-group offset 2*j is applied here.
  for (genvar j = 0; j < DPC; j++) begin : g_digit
    logic [2:0]    trip;
    booth_act_t    act;
    logic [AW-1:0] mag;

    assign trip = 3'(bx_q >> (2 * (int'(cnt_q) + j)));

    booth_radix4_enc u_enc (
      .trip (trip),
      .act  (act)
    );

    assign mag   = act.one ? mcand_q : (act.two ? (mcand_q << 1) : '0);
    assign pp[j] = ((act.neg && (|mag)) ? (~mag + 1'b1) : mag) << (2 * j);
  end

  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < DPC; j++) begin
      acc_d = acc_d + pp[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_grp) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_p     = p_q;

  // b is extended past its sign so trailing digits of a partial last group recode to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q   <= 1'b0;
      mcand_q <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else if (accept) begin
      sgn_q   <= in_signed;
      mcand_q <= {{(AW - WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
      bx_q    <= {{(BW - WIDTH){in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_q + CW'(DPC);
      mcand_q <= mcand_q << (2 * DPC);
      if (last_grp) begin
        p_q <= acc_d[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult across WIDTH 8/16 and DPC 1/3/4/9 with a reference multiply.
module tb_booth_seq_mult;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid_s  [NI];
  logic        in_ready_s  [NI];
  logic        in_signed_s [NI];
  logic [15:0] a_s         [NI];
  logic [15:0] b_s         [NI];
  logic        out_valid_s [NI];
  logic        out_ready_s [NI];
  logic [31:0] p_s         [NI];
  logic [15:0] p0, p1;
  logic [31:0] p2, p3, p4;

  assign p_s[0] = 32'(p0);
  assign p_s[1] = 32'(p1);
  assign p_s[2] = p2;
  assign p_s[3] = p3;
  assign p_s[4] = p4;

  booth_seq_mult #(.WIDTH(8), .DPC(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_signed(in_signed_s[0]), .in_a(a_s[0][7:0]), .in_b(b_s[0][7:0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_p(p0));
  booth_seq_mult #(.WIDTH(8), .DPC(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_signed(in_signed_s[1]), .in_a(a_s[1][7:0]), .in_b(b_s[1][7:0]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_p(p1));
  booth_seq_mult #(.WIDTH(16), .DPC(1)) u_w16d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .in_signed(in_signed_s[2]), .in_a(a_s[2]), .in_b(b_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .out_p(p2));
  booth_seq_mult #(.WIDTH(16), .DPC(3)) u_w16d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
    .in_signed(in_signed_s[3]), .in_a(a_s[3]), .in_b(b_s[3]),
    .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]), .out_p(p3));
  booth_seq_mult #(.WIDTH(16), .DPC(9)) u_w16d9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[4]), .in_ready(in_ready_s[4]),
    .in_signed(in_signed_s[4]), .in_a(a_s[4]), .in_b(b_s[4]),
    .out_valid(out_valid_s[4]), .out_ready(out_ready_s[4]), .out_p(p4));

  typedef struct {
    logic [31:0] p;
    int          lat;
  } exp_t;

  typedef struct {
    int          k;
    bit          sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          lat;
    int          hold;
  } vec_t;

  exp_t sb [NI][$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int w_of(input int k);
    return (k < 2) ? 8 : 16;
  endfunction

  function automatic int dpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      2:       return 1;
      3:       return 3;
      default: return 9;
    endcase
  endfunction

  function automatic int exp_cyc(input int w, input int dpc, input bit sgn);
    int d;
    d = sgn ? w / 2 : w / 2 + 1;
    return (d + dpc - 1) / dpc;
  endfunction

  function automatic logic [31:0] ref_mul(input int w, input bit sgn,
                                          input logic [15:0] a, input logic [15:0] b);
    longint x, y, m, p;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (sgn && x[w-1]) x = x - (longint'(1) << w);
    if (sgn && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int k, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] ep, input int el, input int hold, input string nm);
    exp_t e;
    int   lat;
    int   wt;
    e.p   = ep;
    e.lat = el;
    sb[k].push_back(e);
    @(negedge clk);
    in_valid_s[k]  = 1'b1;
    in_signed_s[k] = sgn;
    a_s[k]         = a;
    b_s[k]         = b;
    wt = 0;
    while (!in_ready_s[k] && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    if (!in_ready_s[k]) begin
      chk({nm, " accept"}, 64'(in_ready_s[k]), 64'd1);
      in_valid_s[k] = 1'b0;
      void'(sb[k].pop_front());
      return;
    end
    @(posedge clk);
    #1;
    in_valid_s[k]  = 1'b0;
    in_signed_s[k] = ~sgn;
    a_s[k]         = 16'($urandom);
    b_s[k]         = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid_s[k] && lat < 40);
    e = sb[k].pop_front();
    chk({nm, " latency"}, 64'(lat), 64'(e.lat));
    chk({nm, " product"}, 64'(p_s[k]), 64'(e.p));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({nm, " hold out_valid"}, 64'(out_valid_s[k]), 64'd1);
      chk({nm, " hold out_p"}, 64'(p_s[k]), 64'(e.p));
      chk({nm, " hold in_ready"}, 64'(in_ready_s[k]), 64'd0);
    end
    out_ready_s[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[k] = 1'b0;
    if (hold > 0) begin
      chk({nm, " release out_valid"}, 64'(out_valid_s[k]), 64'd0);
      chk({nm, " release in_ready"}, 64'(in_ready_s[k]), 64'd1);
    end
  endtask

  task automatic rand_run(input int k, input int n);
    int w;
    int dpc;
    w   = w_of(k);
    dpc = dpc_of(k);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < n; i++) begin
        logic [15:0] a;
        logic [15:0] b;
        bit          sgn;
        sgn = (m == 1);
        a = 16'($urandom);
        b = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
        if (i % 16 == 5) begin
          a = 16'h8000;
          b = 16'h8000;
        end
        do_op(k, sgn, a, b, ref_mul(w, sgn, a, b), exp_cyc(w, dpc, sgn), 0,
              $sformatf("rand k%0d s%0d a%0h b%0h", k, sgn, a, b));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [12];
    for (int k = 0; k < NI; k++) begin
      in_valid_s[k]  = 1'b0;
      in_signed_s[k] = 1'b0;
      a_s[k]         = '0;
      b_s[k]         = '0;
      out_ready_s[k] = 1'b0;
    end

    vecs[0]  = '{k: 0, sgn: 1, a: 16'h0080, b: 16'h0080, p: 32'h0000_4000, lat: 4, hold: 0};
    vecs[1]  = '{k: 0, sgn: 0, a: 16'h00FF, b: 16'h00FF, p: 32'h0000_FE01, lat: 5, hold: 0};
    vecs[2]  = '{k: 0, sgn: 1, a: 16'h0007, b: 16'h00FD, p: 32'h0000_FFEB, lat: 4, hold: 3};
    vecs[3]  = '{k: 0, sgn: 0, a: 16'h0080, b: 16'h0080, p: 32'h0000_4000, lat: 5, hold: 0};
    vecs[4]  = '{k: 0, sgn: 1, a: 16'h007F, b: 16'h0080, p: 32'h0000_C080, lat: 4, hold: 0};
    vecs[5]  = '{k: 1, sgn: 1, a: 16'h00FF, b: 16'h00FF, p: 32'h0000_0001, lat: 1, hold: 0};
    vecs[6]  = '{k: 1, sgn: 0, a: 16'h00C8, b: 16'h0003, p: 32'h0000_0258, lat: 2, hold: 0};
    vecs[7]  = '{k: 2, sgn: 1, a: 16'h8000, b: 16'h8000, p: 32'h4000_0000, lat: 8, hold: 0};
    vecs[8]  = '{k: 4, sgn: 0, a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE_0001, lat: 1, hold: 0};
    vecs[9]  = '{k: 4, sgn: 1, a: 16'hFFFF, b: 16'hFFFF, p: 32'h0000_0001, lat: 1, hold: 0};
    vecs[10] = '{k: 3, sgn: 0, a: 16'h04D2, b: 16'hFFFF, p: 32'h04D1_FB2E, lat: 3, hold: 0};
    vecs[11] = '{k: 3, sgn: 1, a: 16'h0003, b: 16'hFFFB, p: 32'hFFFF_FFF1, lat: 3, hold: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset in_ready k%0d", k), 64'(in_ready_s[k]), 64'd1);
      chk($sformatf("reset out_valid k%0d", k), 64'(out_valid_s[k]), 64'd0);
      chk($sformatf("reset out_p k%0d", k), 64'(p_s[k]), 64'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].k, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat,
            vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset two cycles into an operation: nothing may come out of it.
    @(negedge clk);
    in_valid_s[0]  = 1'b1;
    in_signed_s[0] = 1'b0;
    a_s[0]         = 16'h0055;
    b_s[0]         = 16'h0033;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midop busy in_ready", 64'(in_ready_s[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midop reset out_valid", 64'(out_valid_s[0]), 64'd0);
    chk("midop reset in_ready", 64'(in_ready_s[0]), 64'd1);
    chk("midop reset out_p", 64'(p_s[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 5, 0, "post-reset 3x5");

    fork
      rand_run(2, 250);
      rand_run(3, 250);
      rand_run(4, 250);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
